// File: rtl/multi_code_access_ctrl.sv
`default_nettype none
// ===========================================================================
// multi_code_access_ctrl : keypad door lock with latched day/night code,
// consecutive-failure counting, timed door opening and timed alarm.
// Revision : 1.0
// ===========================================================================
module multi_code_access_ctrl #(
   parameter int CODE_LEN      = 5,
   parameter int DIGIT_W       = 4,
   parameter int MAX_FAIL      = 3,
   parameter int OPEN_CYCLES   = 8,
   parameter int ALARM_CYCLES  = 16,
   parameter int ENTRY_TIMEOUT = 32
) (
   input  logic                            clk,
   input  logic                            RESET,
   input  logic                            day,
   input  logic                            key_valid,
   input  logic [DIGIT_W-1:0]              key_digit,
   input  logic                            cancel,
   input  logic                            alarm_clr,
   input  logic [CODE_LEN*DIGIT_W-1:0]     DAY_CODE,
   input  logic [CODE_LEN*DIGIT_W-1:0]     NIGHT_CODE,
   output logic                            DOOR_OPEN_CLOSE,
   output logic                            ALARM,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
   output logic                            busy
);

   localparam int c_IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int c_FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int c_TMR_MAX = (OPEN_CYCLES > ALARM_CYCLES) ?
                              ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT) :
                              ((ALARM_CYCLES > ENTRY_TIMEOUT) ? ALARM_CYCLES : ENTRY_TIMEOUT);
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

   localparam logic [c_IDX_W-1:0]  c_LAST_IDX   = c_IDX_W'(CODE_LEN - 1);
   localparam logic [c_FAIL_W-1:0] c_MAX_FAIL   = c_FAIL_W'(MAX_FAIL);
   localparam logic [c_TMR_W-1:0]  c_OPEN_LAST  = c_TMR_W'(OPEN_CYCLES - 1);
   localparam logic [c_TMR_W-1:0]  c_ALARM_LAST = c_TMR_W'(ALARM_CYCLES - 1);
   localparam logic [c_TMR_W-1:0]  c_TMO_LAST   = c_TMR_W'(ENTRY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_OPEN  = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   state_t                 state_q;
   logic                   mode_q;
   logic [c_IDX_W-1:0]     idx_q;
   logic                   mismatch_q;
   logic [c_TMR_W-1:0]     tmr_q;
   logic [c_FAIL_W-1:0]    fail_q;
   logic                   door_q;
   logic                   alarm_q;
   logic                   busy_q;

   logic [c_FAIL_W-1:0]    fail_d;

   logic                       w_mode;
   logic [c_IDX_W-1:0]         w_idx;
   logic [CODE_LEN*DIGIT_W-1:0] w_code;
   logic [DIGIT_W-1:0]         w_digits [CODE_LEN];
   logic                       w_accept;
   logic                       w_last;
   logic                       w_bad;

   // In IDLE the first digit picks the code from the live day input; afterwards the latched mode rules.
   assign w_mode   = (state_q == S_IDLE) ? day : mode_q;
   assign w_idx    = (state_q == S_IDLE) ? '0 : idx_q;

   always_comb begin
      w_code = w_mode ? DAY_CODE : NIGHT_CODE;
      for (int i = 0; i < CODE_LEN; i++) begin
         w_digits[i] = w_code[i*DIGIT_W +: DIGIT_W];
      end
   end

   assign w_accept = key_valid &&
                     ((state_q == S_IDLE) || ((state_q == S_ENTRY) && !cancel));
   assign w_last   = (w_idx == c_LAST_IDX);
   assign w_bad    = mismatch_q || (key_digit != w_digits[w_idx]);
   assign fail_d   = (fail_q == c_MAX_FAIL) ? fail_q : fail_q + 1'b1;

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         tmr_q      <= '0;
         fail_q     <= '0;
         door_q     <= 1'b0;
         alarm_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else if (w_accept) begin
         tmr_q <= '0;
         if (state_q == S_IDLE) begin
            mode_q <= day;
         end
         if (w_last) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            if (!w_bad) begin
               state_q <= S_OPEN;
               door_q  <= 1'b1;
               fail_q  <= '0;
               busy_q  <= 1'b1;
            end else if (fail_d == c_MAX_FAIL) begin
               state_q <= S_ALARM;
               alarm_q <= 1'b1;
               fail_q  <= fail_d;
               busy_q  <= 1'b1;
            end else begin
               state_q <= S_IDLE;
               fail_q  <= fail_d;
               busy_q  <= 1'b0;
            end
         end else begin
            state_q    <= S_ENTRY;
            idx_q      <= w_idx + 1'b1;
            mismatch_q <= w_bad;
            busy_q     <= 1'b1;
         end
      end else begin
         case (state_q)
            S_ENTRY: begin
               if (cancel || (tmr_q == c_TMO_LAST)) begin
                  state_q    <= S_IDLE;
                  idx_q      <= '0;
                  mismatch_q <= 1'b0;
                  tmr_q      <= '0;
                  busy_q     <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            S_OPEN: begin
               if (tmr_q == c_OPEN_LAST) begin
                  state_q <= S_IDLE;
                  door_q  <= 1'b0;
                  tmr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            S_ALARM: begin
               if (alarm_clr || (tmr_q == c_ALARM_LAST)) begin
                  state_q <= S_IDLE;
                  alarm_q <= 1'b0;
                  fail_q  <= '0;
                  tmr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign DOOR_OPEN_CLOSE = door_q;
   assign ALARM           = alarm_q;
   assign fail_cnt        = fail_q;
   assign busy            = busy_q;

endmodule
`default_nettype wire

// File: doc/multi_code_access_ctrl.md
MULTI_CODE_ACCESS_CTRL -- requirements
Module: multi_code_access_ctrl

Interface
REQ-001 SHALL provide parameter CODE_LEN, 5, number of digits per access code (>=1).
REQ-002 SHALL provide parameter DIGIT_W, 4, width of one keypad digit.
REQ-003 SHALL provide parameter MAX_FAIL, 3, consecutive failed codes that trigger ALARM (>=1).
REQ-004 SHALL provide parameter OPEN_CYCLES, 8, clk cycles the door stays open (>=1).
REQ-005 SHALL provide parameter ALARM_CYCLES, 16, clk cycles ALARM stays asserted (>=1).
REQ-006 SHALL provide parameter ENTRY_TIMEOUT, 32, idle clk cycles allowed between digits before entry aborts (>=1).
REQ-007 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-008 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port day  input  1  1 = day mode (DAY_CODE valid), 0 = night mode (NIGHT_CODE valid).
REQ-010 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_digit.
REQ-011 SHALL have port key_digit  input  DIGIT_W  entered digit.
REQ-012 SHALL have port cancel  input  1  abort current entry.
REQ-013 SHALL have port alarm_clr  input  1  early alarm acknowledge.
REQ-014 SHALL have port DAY_CODE  input  CODE_LEN*DIGIT_W  day code; digit i at bits [i*DIGIT_W +: DIGIT_W], digit 0 entered first.
REQ-015 SHALL have port NIGHT_CODE  input  CODE_LEN*DIGIT_W  night code, same packing.
REQ-016 SHALL have port DOOR_OPEN_CLOSE  output  1  1 = door unlocked.
REQ-017 SHALL have port ALARM  output  1  alarm active.
REQ-018 SHALL have port fail_cnt  output  clog2(MAX_FAIL+1)  consecutive failed codes.
REQ-019 SHALL have port busy  output  1  1 when state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, ENTRY, OPEN, ALARM; all outputs registered.
REQ-021 IDLE: key_valid SHALL latch mode (day) for the whole entry, compare the digit to digit 0 of the selected code, set digit index to 1 and go to ENTRY; if CODE_LEN=1 the code completes immediately per REQ-023.
REQ-022 ENTRY: each key_valid SHALL compare key_digit to selected-code digit at current index, set a sticky mismatch flag on inequality, increment index, reset inactivity timer; a wrong digit SHALL NOT end entry early.
REQ-023 On the digit completing CODE_LEN digits: no mismatch -> OPEN, fail_cnt cleared; mismatch -> fail_cnt+1, then ALARM if fail_cnt reaches MAX_FAIL, else IDLE.
REQ-024 DOOR_OPEN_CLOSE SHALL rise the cycle after the edge sampling the last correct digit and stay high exactly OPEN_CYCLES cycles, then go IDLE.
REQ-025 ALARM SHALL rise the cycle after the edge sampling the failing last digit and stay high ALARM_CYCLES cycles, then go IDLE with fail_cnt cleared.
REQ-026 alarm_clr in ALARM SHALL end ALARM at that edge, clear fail_cnt, go IDLE; ignored elsewhere.
REQ-027 ENTRY with no key_valid for ENTRY_TIMEOUT consecutive cycles SHALL go IDLE, discard entry, fail_cnt unchanged.
REQ-028 cancel in ENTRY SHALL go IDLE, discard entry, fail_cnt unchanged; cancel wins over simultaneous key_valid.
REQ-029 key_valid and cancel SHALL be ignored in OPEN and ALARM; no keys are buffered.
REQ-030 day changing mid-entry SHALL not affect the code in use; DAY_CODE/NIGHT_CODE SHALL be sampled live per digit.
REQ-031 fail_cnt SHALL saturate at MAX_FAIL; only successful code, alarm end or reset clears it.
REQ-032 DOOR_OPEN_CLOSE and ALARM SHALL never be high together.

Reset
REQ-033 RESET low SHALL immediately force IDLE, DOOR_OPEN_CLOSE=0, ALARM=0, fail_cnt=0, busy=0, index, mismatch flag and timers cleared, in any state.
REQ-034 First valid key SHALL be sampled at the first rising edge after RESET deasserts.

Verification (defaults; DAY_CODE=1,1,1,1,1; NIGHT_CODE=5,3,A,1,7)
REQ-035 day=1, keys 1,1,1,1,1 -> DOOR_OPEN_CLOSE high cycle after 5th key for exactly 8 cycles, fail_cnt=0.
REQ-036 day=0, keys 5,3,A,1,7 -> door opens; day=0, keys 1,1,1,1,1 -> no open, fail_cnt=1, IDLE.
REQ-037 Three wrong 5-digit codes -> fail_cnt 1,2, then ALARM high 16 cycles, fail_cnt 0 after; alarm_clr in cycle 4 ends ALARM next edge.
REQ-038 day=1, keys 1,1 then 32 idle cycles -> IDLE, fail_cnt unchanged; cancel with key_valid same cycle -> IDLE, key ignored.
REQ-039 RESET low mid-OPEN and mid-ALARM -> outputs 0 immediately, fail_cnt 0; day toggled after 1st digit -> latched code still used.
